// File: rtl/data_mem_responder.sv
// Zero-wait data-memory responder for the MEM stage: word RAM plus an MMIO page
// holding a cycle counter, scratch register, console TX FIFO and sticky error status.
module data_mem_responder #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000,
    parameter int unsigned FIFO_DEPTH  = 8
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] DataMemAddr,
    input  logic        DataMemRead,
    input  logic        DataMemWrite,
    input  logic [31:0] DataMemWData,
    output logic [31:0] DataMemRData,
    output logic [7:0]  ConsoleData,
    output logic        ConsoleValid,
    input  logic        ConsoleReady,
    output logic        ErrFlag
);
    localparam int unsigned AW        = $clog2(DEPTH_WORDS);
    localparam int unsigned PW        = $clog2(FIFO_DEPTH);
    localparam int unsigned CW        = PW + 1;
    localparam logic [31:0] RAM_BYTES = 32'(DEPTH_WORDS * 4);

    localparam logic [7:0] OFF_CYCLE   = 8'h00;
    localparam logic [7:0] OFF_TX      = 8'h04;
    localparam logic [7:0] OFF_STATUS  = 8'h08;
    localparam logic [7:0] OFF_CLR     = 8'h0C;
    localparam logic [7:0] OFF_SCRATCH = 8'h10;

    logic [31:0]   r_mem [DEPTH_WORDS];
    logic [7:0]    r_fifo [FIFO_DEPTH];
    logic [31:0]   r_cycle;
    logic [31:0]   r_scratch;
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_ovf;
    logic          r_err;

    logic          w_access;
    logic          w_aligned;
    logic          w_ram_hit;
    logic          w_mmio_hit;
    logic [7:0]    w_off;
    logic          w_known_off;
    logic          w_ro_off;
    logic          w_err;
    logic          w_mmio_wr;
    logic          w_ram_we;
    logic          w_scratch_we;
    logic          w_clr;
    logic          w_push;
    logic          w_push_ok;
    logic          w_pop;
    logic          w_full;
    logic          w_empty;
    logic [AW-1:0] w_ram_idx;
    logic [31:0]   w_status;
    logic [31:0]   w_rdata;

    // Address decode and access-error classification
    always_comb begin
        w_access    = DataMemRead || DataMemWrite;
        w_aligned   = (DataMemAddr[1:0] == 2'b00);
        w_ram_hit   = (DataMemAddr < RAM_BYTES);
        w_mmio_hit  = (DataMemAddr[31:16] == MMIO_BASE[31:16]);
        w_off       = DataMemAddr[7:0];
        w_ram_idx   = DataMemAddr[AW+1:2];
        w_known_off = (w_off == OFF_CYCLE) || (w_off == OFF_TX) || (w_off == OFF_STATUS) ||
                      (w_off == OFF_CLR) || (w_off == OFF_SCRATCH);
        w_ro_off    = (w_off == OFF_CYCLE) || (w_off == OFF_STATUS);
        w_err       = w_access && (!w_aligned || !(w_ram_hit || w_mmio_hit) ||
                      (w_mmio_hit && !w_known_off) ||
                      (DataMemWrite && w_mmio_hit && w_ro_off));
    end

    // Write enables are all gated by a clean (error-free) access
    always_comb begin
        w_mmio_wr    = DataMemWrite && !w_err && w_mmio_hit;
        w_ram_we     = DataMemWrite && !w_err && w_ram_hit;
        w_scratch_we = w_mmio_wr && (w_off == OFF_SCRATCH);
        w_clr        = w_mmio_wr && (w_off == OFF_CLR);
        w_push       = w_mmio_wr && (w_off == OFF_TX);
        w_empty      = (r_count == '0);
        w_full       = (r_count == CW'(FIFO_DEPTH));
        w_pop        = !w_empty && ConsoleReady;
        w_push_ok    = w_push && (!w_full || w_pop);
        w_status     = {16'h0000, 4'(r_count), 2'b00, r_err, r_ovf, 6'b000000, w_full, w_empty};
    end

    // Same-cycle read mux; RAM reads see the pre-write contents
    always_comb begin
        w_rdata = '0;
        if (DataMemRead && !w_err) begin
            if (w_ram_hit) begin
                w_rdata = r_mem[w_ram_idx];
            end else begin
                case (w_off)
                    OFF_CYCLE:   w_rdata = r_cycle;
                    OFF_STATUS:  w_rdata = w_status;
                    OFF_SCRATCH: w_rdata = r_scratch;
                    default:     w_rdata = '0;
                endcase
            end
        end
    end

    // Storage arrays carry no reset
    always_ff @(posedge CLK) begin
        if (w_ram_we) begin
            r_mem[w_ram_idx] <= DataMemWData;
        end
        if (w_push_ok) begin
            r_fifo[r_wr_ptr] <= DataMemWData[7:0];
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_cycle   <= '0;
            r_scratch <= '0;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_ovf     <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_cycle <= r_cycle + 32'd1;
            if (w_scratch_we) begin
                r_scratch <= DataMemWData;
            end
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            r_count <= r_count + CW'(w_push_ok) - CW'(w_pop);
            // A new event outranks a same-cycle W1C clear
            if (w_push && w_full && !w_pop) begin
                r_ovf <= 1'b1;
            end else if (w_clr && DataMemWData[8]) begin
                r_ovf <= 1'b0;
            end
            if (w_err) begin
                r_err <= 1'b1;
            end else if (w_clr && DataMemWData[9]) begin
                r_err <= 1'b0;
            end
        end
    end

    assign DataMemRData = w_rdata;
    assign ConsoleValid = !w_empty;
    assign ConsoleData  = w_empty ? 8'h00 : r_fifo[r_rd_ptr];
    assign ErrFlag      = r_err;

endmodule
